// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: XADC-style DRP slave with an emulated free-running VAUX6 conversion
//   CLK, reset_in            : clock, synchronous active-high reset
//   daddr_in/den_in/dwe_in/di_in : DRP request (den_in is a one-cycle strobe)
//   sample_in                : 12-bit code latched at each end of conversion
//   do_out/drdy_out          : DRP read data and completion strobe
//   busy_out/eoc_out/eos_out/channel_out : conversion status
//   Macro XADC_DRP_WRITE_EN  : makes configuration registers 0x40-0x42 writable
module xadc_drp_responder #(
  parameter int CONV_CYCLES = 26,
  parameter int DRP_LATENCY = 4
) (
  input  logic        CLK,
  input  logic        reset_in,
  input  logic [6:0]  daddr_in,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [15:0] di_in,
  input  logic [11:0] sample_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  output logic        busy_out,
  output logic        eoc_out,
  output logic        eos_out,
  output logic [4:0]  channel_out
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [9:0] LAST = 10'(CONV_CYCLES - 1);
  localparam logic [3:0] LAT0 = 4'(DRP_LATENCY - 2);
  logic [1:0]  state;
  logic [3:0]  lat;
  logic [6:0]  addr;
  logic        we;
  logic [9:0]  cnt;
  logic        run;
  logic        term;
  logic [15:0] result;
  logic [15:0] do_q;
  logic [15:0] rdata;
  logic        cfg_hit;
  // run keeps busy_out low for the cycle the counter sits at 0 straight out of reset
  assign term     = cnt == LAST;
  assign busy_out = run && !term;
  assign cfg_hit  = addr[6:2] == 5'b10000 && addr[1:0] != 2'b11;
  always_ff @(posedge CLK) begin
    if (reset_in) begin
      cnt         <= '0;
      run         <= 1'b0;
      result      <= '0;
      eoc_out     <= 1'b0;
      eos_out     <= 1'b0;
      channel_out <= '0;
    end else begin
      run     <= 1'b1;
      cnt     <= term ? '0 : cnt + 10'd1;
      eoc_out <= term;
      eos_out <= term;
      if (term) begin
        result      <= {sample_in, 4'h0};
        channel_out <= 5'h16;
      end
    end
  end
`ifdef XADC_DRP_WRITE_EN
  logic [15:0] wdata;
  logic [15:0] cfg [4];
  always_ff @(posedge CLK) begin
    if (reset_in) begin
      for (int i = 0; i < 4; i++) cfg[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (state == RESP && we && cfg_hit && addr[1:0] == 2'(i)) cfg[i] <= wdata;
    end
  end
  always_ff @(posedge CLK) begin
    if (reset_in) wdata <= '0;
    else if (state == IDLE && den_in) wdata <= di_in;
  end
  always_comb rdata = addr == 7'h16 ? result : cfg_hit ? cfg[addr[1:0]] : 16'h0000;
`else
  logic unused_wr;
  assign unused_wr = ^{di_in, cfg_hit};
  always_comb rdata = addr == 7'h16 ? result : 16'h0000;
`endif
  // Read data is taken live in RESP so a conversion landing up to that cycle is seen
  assign drdy_out = state == RESP;
  assign do_out   = (drdy_out && !we) ? rdata : do_q;
  always_ff @(posedge CLK) begin
    if (reset_in) begin
      state <= IDLE;
      lat   <= '0;
      addr  <= '0;
      we    <= 1'b0;
      do_q  <= '0;
    end else begin
      do_q <= do_out;
      case (state)
        IDLE: if (den_in) begin
          addr  <= daddr_in;
          we    <= dwe_in;
          lat   <= LAT0;
          state <= WAIT;
        end
        WAIT: begin
          lat   <= lat - 4'd1;
          state <= lat == 4'd0 ? RESP : WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/xadc_drp_responder.md
XADC_DRP_RESPONDER -- requirements
Module: xadc_drp_responder

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 26, CLK cycles per emulated conversion (legal range 4..1023).
REQ-002 SHALL have parameter DRP_LATENCY, default 4, CLK cycles from accepted den_in to drdy_out (legal range 2..15).
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port reset_in  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port daddr_in  input  7  DRP register address.
REQ-006 SHALL have port den_in  input  1  DRP enable, one-cycle request strobe.
REQ-007 SHALL have port dwe_in  input  1  DRP write enable, qualified by den_in.
REQ-008 SHALL have port di_in  input  16  DRP write data.
REQ-009 SHALL have port sample_in  input  12  analog-equivalent code for channel VAUX6.
REQ-010 SHALL have port do_out  output  16  DRP read data.
REQ-011 SHALL have port drdy_out  output  1  DRP completion strobe.
REQ-012 SHALL have port busy_out  output  1  conversion in progress.
REQ-013 SHALL have port eoc_out  output  1  end-of-conversion pulse.
REQ-014 SHALL have port eos_out  output  1  end-of-sequence pulse.
REQ-015 SHALL have port channel_out  output  5  channel of last conversion.

Function
REQ-016 Conversion counter SHALL count 0..CONV_CYCLES-1 continuously; busy_out high while counting, low only on the terminal-count cycle.
REQ-017 On terminal count, the block SHALL latch {sample_in,4'h0} into result register 0x16 and pulse eoc_out and eos_out high for exactly one cycle.
REQ-018 channel_out SHALL read 5'h16 from the first eoc_out onward.
REQ-019 DRP FSM SHALL have states IDLE, WAIT, RESP.
REQ-020 In IDLE, den_in=1 SHALL capture daddr_in, dwe_in, di_in, load the latency counter, and move to WAIT.
REQ-021 WAIT SHALL last DRP_LATENCY-1 cycles, then move to RESP; drdy_out therefore rises exactly DRP_LATENCY cycles after the den_in cycle.
REQ-022 In RESP, drdy_out SHALL be high for one cycle, do_out SHALL present the addressed register value, and the FSM SHALL return to IDLE.
REQ-023 Read map: 0x16 = result register; 0x40, 0x41, 0x42 = configuration registers; every other address reads 16'h0000.
REQ-024 Read data SHALL be sampled in the RESP cycle, so a conversion update that lands at any point before RESP SHALL be visible.
REQ-025 A den_in asserted outside IDLE SHALL be ignored, with no queueing and no second drdy_out.
REQ-026 A den_in asserted in the RESP cycle SHALL be ignored; a new request is accepted no earlier than the cycle after drdy_out.
REQ-027 do_out SHALL hold its last value between transactions; a write transaction SHALL leave do_out unchanged.
REQ-028 A write transaction SHALL still produce drdy_out with the same latency as a read.

Reset
REQ-029 reset_in=1 at a rising CLK SHALL force the DRP FSM to IDLE and the conversion counter to 0.
REQ-030 During reset, outputs SHALL be: do_out=0, drdy_out=0, busy_out=0, eoc_out=0, eos_out=0, channel_out=0.
REQ-031 Reset SHALL clear the result register and the configuration registers to 16'h0000.
REQ-032 A reset during WAIT SHALL abort the transaction with no drdy_out; the first conversion SHALL complete CONV_CYCLES cycles after reset is released.

Configuration
REQ-033 With macro XADC_DRP_WRITE_EN defined, a write to 0x40-0x42 SHALL update that register on the RESP cycle and be read back afterwards.
REQ-034 Without XADC_DRP_WRITE_EN, all writes SHALL be discarded, 0x40-0x42 SHALL read 16'h0000, and drdy_out SHALL still be returned per REQ-028.
REQ-035 Writes to any other address SHALL be discarded in both builds.

Verification
REQ-036 Defaults, sample_in=12'hABC, run 60 cycles after reset -> eoc_out pulses on cycles 26 and 52 after release, with eos_out coincident, channel_out=5'h16.
REQ-037 After the first eoc_out, read 0x16 with den_in at cycle T -> drdy_out at T+4, do_out=16'hABC0, single-cycle drdy_out.
REQ-038 Read 0x16 issued 2 cycles before eoc_out while sample_in changes 12'h100 -> 12'h200 -> do_out=16'h2000.
REQ-039 den_in pulses on cycles T and T+2 -> exactly one drdy_out, at T+4.
REQ-040 With XADC_DRP_WRITE_EN, write 0x41=16'h1234 then read 0x41 -> do_out=16'h1234; without the macro -> do_out=16'h0000, drdy_out present in both builds.
REQ-041 reset_in at T+2 after a read issued at T -> no drdy_out; do_out=0; busy_out low during reset and high the cycle after release.
